// File: rtl/ntr_cmd_capture.sv
// ntr_cmd_capture: synchronise NTR pins, assemble the first CMD_BYTES bytes of a CS1 frame, hand off via valid/ready
module ntr_cmd_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8,
  parameter int CMD_BYTES   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ntr_clk,
  input  logic                        ntr_cs1,
  input  logic [DATA_W-1:0]           ntr_data_in,
  output logic [DATA_W*CMD_BYTES-1:0] cmd_data,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [3:0]                  byte_count,
  output logic                        overrun,
  output logic                        frame_error
);
  localparam int CMD_W = DATA_W * CMD_BYTES;
  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync, cs_sync;
  logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
  logic [CMD_W-1:0]       shift;
  logic                   clk_q, done, clk_rise, cs_act, last;
  assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_q;
  assign cs_act   = ~cs_sync[SYNC_STAGES-1];
  assign last     = byte_count == 4'(CMD_BYTES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync    <= '0;
      cs_sync     <= '1;
      data_sync   <= '{default: '0};
      clk_q       <= 1'b0;
      state       <= IDLE;
      shift       <= '0;
      done        <= 1'b0;
      cmd_data    <= '0;
      cmd_valid   <= 1'b0;
      byte_count  <= '0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      clk_sync     <= {clk_sync[SYNC_STAGES-2:0], ntr_clk};
      cs_sync      <= {cs_sync[SYNC_STAGES-2:0], ntr_cs1};
      data_sync[0] <= ntr_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      clk_q       <= clk_sync[SYNC_STAGES-1];
      overrun     <= 1'b0;
      frame_error <= 1'b0;
      done        <= 1'b0;
      if (done) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_data  <= shift;
          cmd_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (cmd_ready) cmd_valid <= 1'b0;
      if (!cs_act) begin
        frame_error <= state == RECV && byte_count != 0;
        state       <= IDLE;
        byte_count  <= '0;
      end else if (clk_rise && state != DRAIN) begin
        shift      <= {shift[CMD_W-DATA_W-1:0], data_sync[SYNC_STAGES-1]};
        byte_count <= byte_count + 4'd1;
        done       <= last;
        state      <= last ? DRAIN : RECV;
      end else if (state == IDLE) state <= RECV;
    end
  end
endmodule

// File: tb/tb_ntr_cmd_capture.sv
// tb_ntr_cmd_capture: directed self-checking bench for ntr_cmd_capture
module tb_ntr_cmd_capture;
  logic        clk = 0, rst = 1, ntr_clk = 0, ntr_cs1 = 1, cmd_ready = 1;
  logic [7:0]  ntr_data_in = 0;
  logic [63:0] cmd_data;
  logic        cmd_valid, overrun, frame_error;
  logic [3:0]  byte_count;
  int          vec = 0, err = 0, ovr_cnt = 0, fe_cnt = 0, vld_cnt = 0;
  int          o0, f0, v0;
  logic [63:0] last_cmd = 0;
  ntr_cmd_capture dut (
    .clk(clk), .rst(rst), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1), .ntr_data_in(ntr_data_in),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .byte_count(byte_count), .overrun(overrun), .frame_error(frame_error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    ovr_cnt += int'(overrun);
    fe_cnt  += int'(frame_error);
    if (cmd_valid) begin
      vld_cnt++;
      last_cmd = cmd_data;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] d);
    ntr_data_in = d;
    repeat (8) @(posedge clk);
    #1 ntr_clk = 1;
    repeat (8) @(posedge clk);
    #1 ntr_clk = 0;
  endtask
  task automatic frame(input logic [95:0] v, input int n);
    ntr_cs1 = 0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) send_byte(v[95-8*i -: 8]);
  endtask
  task automatic release_cs();
    ntr_cs1 = 1;
    repeat (6) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) begin
      @(posedge clk);
      #1 ntr_clk = 1'($urandom); ntr_cs1 = 1'($urandom); ntr_data_in = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_error", frame_error, 0);
    ntr_clk = 0; ntr_cs1 = 1; ntr_data_in = 0;
    @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    #1;
    frame({8'h9F, 88'h0}, 7);
    ntr_data_in = 8'h00;
    repeat (8) @(posedge clk);
    #1 ntr_clk = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1 chk($sformatf("lat_valid_%0d", k), cmd_valid, k == 4);
      if (k == 4) chk("t2_data", cmd_data, 64'h9F00000000000000);
    end
    repeat (3) @(posedge clk);
    #1 ntr_clk = 0;
    chk("t2_count_full", byte_count, 8);
    release_cs();
    chk("t2_count_idle", byte_count, 0);
    chk("t2_no_fe", fe_cnt, 0);
    cmd_ready = 0;
    o0 = ovr_cnt;
    frame({64'h0102030405060708, 32'h0}, 8);
    release_cs();
    chk("t3_valid1", cmd_valid, 1);
    chk("t3_data1", cmd_data, 64'h0102030405060708);
    frame({64'h1112131415161718, 32'h0}, 8);
    release_cs();
    chk("t3_overrun", ovr_cnt - o0, 1);
    chk("t3_data_held", cmd_data, 64'h0102030405060708);
    chk("t3_valid_held", cmd_valid, 1);
    cmd_ready = 1;
    @(negedge clk);
    chk("t3_valid_pre", cmd_valid, 1);
    @(negedge clk);
    chk("t3_valid_drop", cmd_valid, 0);
    @(posedge clk);
    #1;
    f0 = fe_cnt; v0 = vld_cnt;
    frame({24'hA1B2C3, 72'h0}, 3);
    chk("t4_count3", byte_count, 3);
    release_cs();
    chk("t4_fe", fe_cnt - f0, 1);
    chk("t4_no_valid", vld_cnt - v0, 0);
    chk("t4_count0", byte_count, 0);
    f0 = fe_cnt; v0 = vld_cnt;
    frame(96'hC0C1C2C3C4C5C6C7D0D1D2D3, 12);
    chk("t5_count8", byte_count, 8);
    release_cs();
    chk("t5_one_cmd", vld_cnt - v0, 1);
    chk("t5_data", last_cmd, 64'hC0C1C2C3C4C5C6C7);
    chk("t5_no_fe", fe_cnt - f0, 0);
    chk("t5_count0", byte_count, 0);
    f0 = fe_cnt; o0 = ovr_cnt; v0 = vld_cnt;
    frame({40'h5152535455, 56'h0}, 5);
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0; ntr_cs1 = 1;
    chk("t6_rst_count", byte_count, 0);
    chk("t6_rst_valid", cmd_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    frame({64'hAAAAAAAAAAAAAAAA, 32'h0}, 8);
    release_cs();
    chk("t6_data", last_cmd, 64'hAAAAAAAAAAAAAAAA);
    chk("t6_one_cmd", vld_cnt - v0, 1);
    chk("t6_no_fe", fe_cnt - f0, 0);
    chk("t6_no_ovr", ovr_cnt - o0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
